sw_fsm_gen: RTL and testbench

SW_FSM_GEN -- requirements
Module: sw_fsm_gen

---
 rtl/sw_fsm_pkg.sv | 13 +
 rtl/sw_sync.sv | 30 +++
 rtl/sw_fsm_gen.sv | 97 +++++++++
 tb/tb_sw_fsm_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sw_fsm_pkg.sv
// Shared constants for the switch-driven state generator.
package sw_fsm_pkg;

    localparam int unsigned IDLE_ST    = 0;
    localparam int unsigned EDGE_LEVEL = 0;
    localparam int unsigned EDGE_RISE  = 1;

    // Width needed to encode IDLE plus one state per switch.
    function automatic int unsigned state_width(input int unsigned nsw);
        return (nsw < 2) ? 1 : $clog2(nsw + 1);
    endfunction

endpackage

// File: rtl/sw_sync.sv
// Two-flop synchronizer for the switch bank, with a rising-edge detector on the synchronized level.
module sw_sync #(
    parameter int unsigned NSW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NSW-1:0] sw,
    output logic [NSW-1:0] level,
    output logic [NSW-1:0] rise_c
);

    logic [NSW-1:0] meta;
    logic [NSW-1:0] hist;

    // History clears on reset so a switch held through reset shows up as a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= '0;
            level <= '0;
            hist  <= '0;
        end else begin
            meta  <= sw;
            level <= meta;
            hist  <= level;
        end
    end

    assign rise_c = level & ~hist;

endmodule

// File: rtl/sw_fsm_gen.sv
// State generator: lowest-index switch request selects the state, idle timeout, dwell counter.
module sw_fsm_gen
    import sw_fsm_pkg::*;
#(
    parameter int unsigned NSW       = 5,
    parameter int unsigned ZW        = 2,
    parameter int unsigned TIMEOUT   = 8,
    parameter int unsigned EDGE_MODE = 0,
    localparam int unsigned SW_W     = state_width(NSW)
) (
    input  logic            KEY0,
    input  logic            KEY1,
    input  logic [NSW-1:0]  SW,
    output logic [SW_W-1:0] State,
    output logic [ZW-1:0]   Z,
    output logic            Chg
);

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [NSW-1:0]  lvl;
    logic [NSW-1:0]  rise_c;
    logic [NSW-1:0]  req_c;
    logic            req_any_c;
    logic [SW_W-1:0] req_tgt_c;

    logic [SW_W-1:0] state_q, state_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [ZW-1:0]   z_q, z_d;
    logic            chg_q, chg_d;

    sw_sync #(.NSW(NSW)) u_sync (
        .clk    (KEY0),
        .rst    (KEY1),
        .sw     (SW),
        .level  (lvl),
        .rise_c (rise_c)
    );

    // Request source selection and lowest-index priority encoder.
    always_comb begin
        req_c     = (EDGE_MODE == EDGE_LEVEL) ? lvl : rise_c;
        req_any_c = 1'b0;
        req_tgt_c = '0;
        for (int i = NSW - 1; i >= 0; i--) begin
            if (req_c[i]) begin
                req_any_c = 1'b1;
                req_tgt_c = SW_W'(i + 1);
            end
        end
    end

    always_ff @(posedge KEY0) begin
        if (KEY1) begin
            state_q <= SW_W'(IDLE_ST);
            tcnt_q  <= '0;
            z_q     <= '0;
            chg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            z_q     <= z_d;
            chg_q   <= chg_d;
        end
    end

    // Next state; a request always beats an expiring timeout.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        z_d     = z_q;
        if (req_any_c) begin
            state_d = req_tgt_c;
            tcnt_d  = '0;
        end else if (state_q == SW_W'(IDLE_ST)) begin
            tcnt_d = '0;
        end else if (TIMEOUT != 0) begin
            if (tcnt_q == TW'(TIMEOUT - 1)) begin
                state_d = SW_W'(IDLE_ST);
                tcnt_d  = '0;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
        chg_d = (state_d != state_q);
        if (chg_d) begin
            z_d = '0;
        end else if (z_q != '1) begin
            z_d = z_q + ZW'(1);
        end
    end

    assign State = state_q;
    assign Z     = z_q;
    assign Chg   = chg_q;

endmodule

// File: tb/tb_sw_fsm_gen.sv
// Scoreboard bench for sw_fsm_gen: level-mode and edge-mode instances.
module tb_sw_fsm_gen;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] z;
        logic       chg;
    } exp_t;

    logic       KEY0 = 1'b0;
    logic       KEY1 = 1'b1;
    logic [4:0] sw_a = '0;
    logic [4:0] sw_b = '0;
    logic [2:0] st_a, st_b;
    logic [1:0] z_a, z_b;
    logic       chg_a, chg_b;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    sw_fsm_gen #(.NSW(5), .ZW(2), .TIMEOUT(8), .EDGE_MODE(0)) u_lvl (
        .KEY0 (KEY0), .KEY1 (KEY1), .SW (sw_a), .State (st_a), .Z (z_a), .Chg (chg_a)
    );

    sw_fsm_gen #(.NSW(5), .ZW(2), .TIMEOUT(8), .EDGE_MODE(1)) u_edge (
        .KEY0 (KEY0), .KEY1 (KEY1), .SW (sw_b), .State (st_b), .Z (z_b), .Chg (chg_b)
    );

    always #5 KEY0 = ~KEY0;

    task automatic push(input int st, input int z, input int chg);
        exp_t e;
        e.st  = 3'(st);
        e.z   = 2'(z);
        e.chg = 1'(chg);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        KEY1 = 1'b1;
        sw_a = '0;
        sw_b = '0;
        repeat (3) @(posedge KEY0);
        #1;
        KEY1 = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        KEY1 = 1'b1;
        sw_a = 5'b11111;
        sw_b = 5'b11111;
        push(0, 0, 0);
        push(0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge KEY0);
            #1;
            e = sb.pop_front();
            n_chk += 2;
            if ({st_a, z_a, chg_a} !== e) begin
                n_fail++;
                $display("FAIL reset_lvl edge %0d: got st=%0d z=%0d chg=%0d, want st=%0d z=%0d chg=%0d",
                         i, st_a, z_a, chg_a, e.st, e.z, e.chg);
            end
            if ({st_b, z_b, chg_b} !== e) begin
                n_fail++;
                $display("FAIL reset_edge edge %0d: got st=%0d z=%0d chg=%0d, want st=%0d z=%0d chg=%0d",
                         i, st_b, z_b, chg_b, e.st, e.z, e.chg);
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        do_reset();
        sw_a = 5'b00001;
        push(0, 1, 0); push(0, 2, 0); push(1, 0, 1); push(1, 1, 0);
        push(1, 2, 0); push(1, 3, 0); push(1, 3, 0);
        for (int i = 0; i < 7; i++) begin
            @(posedge KEY0);
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({st_a, z_a, chg_a} !== e) begin
                n_fail++;
                $display("FAIL hold edge %0d: got st=%0d z=%0d chg=%0d, want st=%0d z=%0d chg=%0d",
                         i + 1, st_a, z_a, chg_a, e.st, e.z, e.chg);
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        do_reset();
        sw_a = 5'b10100;
        push(0, 1, 0); push(0, 2, 0); push(3, 0, 1); push(3, 1, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge KEY0);
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({st_a, z_a, chg_a} !== e) begin
                n_fail++;
                $display("FAIL priority edge %0d: got st=%0d z=%0d chg=%0d, want st=%0d z=%0d chg=%0d",
                         i + 1, st_a, z_a, chg_a, e.st, e.z, e.chg);
            end
        end
    endtask

    // late_req=1 raises SW[0] so it is synchronized exactly on the expiring edge.
    task automatic test_timeout(input bit late_req);
        exp_t e;
        do_reset();
        sw_a = 5'b00010;
        push(0, 1, 0); push(0, 2, 0); push(2, 0, 1); push(2, 1, 0);
        push(2, 2, 0); push(2, 3, 0);
        for (int k = 0; k < 7; k++) push(2, 3, 0);
        if (late_req) begin
            push(1, 0, 1); push(1, 1, 0);
        end else begin
            push(0, 0, 1); push(0, 1, 0);
        end
        for (int i = 0; i < 15; i++) begin
            @(posedge KEY0);
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({st_a, z_a, chg_a} !== e) begin
                n_fail++;
                $display("FAIL timeout(late_req=%0d) edge %0d: got st=%0d z=%0d chg=%0d, want st=%0d z=%0d chg=%0d",
                         late_req, i + 1, st_a, z_a, chg_a, e.st, e.z, e.chg);
            end
            if (i == 3) sw_a = 5'b00000;
            if (i == 10 && late_req) sw_a = 5'b00001;
        end
    endtask

    task automatic test_edge_mode();
        exp_t e;
        do_reset();
        sw_b = 5'b01000;
        push(0, 1, 0); push(0, 2, 0); push(4, 0, 1); push(4, 1, 0);
        push(4, 2, 0);
        for (int k = 0; k < 5; k++) push(4, 3, 0);
        push(0, 0, 1); push(0, 1, 0); push(0, 2, 0);
        for (int k = 0; k < 7; k++) push(0, 3, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge KEY0);
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({st_b, z_b, chg_b} !== e) begin
                n_fail++;
                $display("FAIL edge_mode edge %0d: got st=%0d z=%0d chg=%0d, want st=%0d z=%0d chg=%0d",
                         i + 1, st_b, z_b, chg_b, e.st, e.z, e.chg);
            end
        end
        sw_b = '0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        sw_a = 5'b01000;
        push(0, 1, 0); push(0, 2, 0); push(4, 0, 1); push(4, 1, 0);
        push(4, 2, 0); push(4, 3, 0);
        push(0, 0, 0);
        push(0, 1, 0); push(0, 2, 0); push(4, 0, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge KEY0);
            #1;
            e = sb.pop_front();
            n_chk++;
            if ({st_a, z_a, chg_a} !== e) begin
                n_fail++;
                $display("FAIL reset_mid edge %0d: got st=%0d z=%0d chg=%0d, want st=%0d z=%0d chg=%0d",
                         i + 1, st_a, z_a, chg_a, e.st, e.z, e.chg);
            end
            if (i == 5) KEY1 = 1'b1;
            if (i == 6) KEY1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_priority();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_edge_mode();
        test_reset_mid();
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
